lab2_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the multi-bit, multi-function, clocked successor of the single-bit gate-level AND. It accepts two WIDTH-bit operands plus a 3-bit opcode per cycle and returns the registered result two cycles later. Supported functions are AND/OR/NAND/NOR/XOR/XNOR and two running-reduction accumulator modes. It sits between the lab's operand registers and the display/check logic, which consumes results via a valid strobe.

---
 rtl/lab2_logic_pipe.sv | 176 +++++++++++++++++
 tb/tb_lab2_logic_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_logic_pipe.sv
// ---------------------------------------------------------------------------
// lab2_logic_pipe
//
// Two-stage pipelined bitwise logic unit. Each cycle it may accept two
// WIDTH-bit operands and a 3-bit opcode. The registered result appears two
// clock edges later, qualified by a one-cycle outValid strobe.
//
// Opcodes:
//   0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR,
//   6 ACC_AND, 7 ACC_OR (running reduction of operand A into an accumulator)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   inValid    operands/opcode valid this cycle
//   inOp       opcode (see above)
//   inA        operand A
//   inB        operand B (ignored by ops 6 and 7)
//   inClr      restart the accumulator
//   outValid   outResult valid this cycle (one-cycle strobe)
//   outResult  registered result
//   outZero    outResult == 0, registered alongside outResult
//   outCount   number of results delivered since reset, wraps
// ---------------------------------------------------------------------------
module lab2_logic_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  input  logic [2:0]         inOp,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  input  logic               inClr,
  output logic               outValid,
  output logic [WIDTH-1:0]   outResult,
  output logic               outZero,
  output logic [COUNT_W-1:0] outCount
);

  localparam logic [2:0] OpAnd    = 3'd0;
  localparam logic [2:0] OpOr     = 3'd1;
  localparam logic [2:0] OpNand   = 3'd2;
  localparam logic [2:0] OpNor    = 3'd3;
  localparam logic [2:0] OpXor    = 3'd4;
  localparam logic [2:0] OpXnor   = 3'd5;
  localparam logic [2:0] OpAccAnd = 3'd6;
  localparam logic [2:0] OpAccOr  = 3'd7;

  // -------------------------------------------------------------------------
  // Stage 1: input capture, unconditional every cycle
  // -------------------------------------------------------------------------
  logic             r_valid;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_op    <= 3'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_valid <= inValid;
      r_op    <= inOp;
      r_a     <= inA;
      r_b     <= inB;
      r_clr   <= inClr;
    end
  end

  // -------------------------------------------------------------------------
  // Gate network: the six plain functions built from or/not primitives only.
  // XNOR falls out as AND | NOR (both-ones or both-zeros), XOR is its inverse.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] w_na;
  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_xnor;
  logic [WIDTH-1:0] w_xor;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    not u_na   (w_na[i],   r_a[i]);
    not u_nb   (w_nb[i],   r_b[i]);
    or  u_nand (w_nand[i], w_na[i],  w_nb[i]);
    not u_and  (w_and[i],  w_nand[i]);
    or  u_or   (w_or[i],   r_a[i],   r_b[i]);
    not u_nor  (w_nor[i],  w_or[i]);
    or  u_xnor (w_xnor[i], w_and[i], w_nor[i]);
    not u_xor  (w_xor[i],  w_xnor[i]);
  end

  // -------------------------------------------------------------------------
  // Stage 2 state
  // -------------------------------------------------------------------------
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_result;
  logic               r_out_zero;
  logic [COUNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_acc;
  logic               r_acc_empty;

  // -------------------------------------------------------------------------
  // Accumulator next value and result select
  // -------------------------------------------------------------------------
  logic             w_is_acc;
  logic             w_acc_restart;
  logic [WIDTH-1:0] w_acc_comb;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_result;

  always_comb begin
    w_is_acc      = (r_op == OpAccAnd) || (r_op == OpAccOr);
    // A clear in the same cycle as an ACC op restarts from A rather than combining.
    w_acc_restart = r_acc_empty | r_clr;
    w_acc_comb    = (r_op == OpAccOr) ? (r_acc | r_a) : (r_acc & r_a);
    w_acc_next    = w_acc_restart ? r_a : w_acc_comb;

    w_result = '0;
    case (r_op)
      OpAnd:    w_result = w_and;
      OpOr:     w_result = w_or;
      OpNand:   w_result = w_nand;
      OpNor:    w_result = w_nor;
      OpXor:    w_result = w_xor;
      OpXnor:   w_result = w_xnor;
      OpAccAnd: w_result = w_acc_next;
      OpAccOr:  w_result = w_acc_next;
      default:  w_result = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2: result, flags, counter and accumulator registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_count      <= '0;
      r_acc        <= '0;
      r_acc_empty  <= 1'b1;
    end else begin
      r_out_valid <= r_valid;

      if (r_valid) begin
        r_out_result <= w_result;
        r_out_zero   <= ~|w_result;
        r_count      <= r_count + COUNT_W'(1);
      end

      // Only a valid ACC op loads/combines; a clear otherwise empties the acc.
      if (r_valid && w_is_acc) begin
        r_acc       <= w_acc_next;
        r_acc_empty <= 1'b0;
      end else if (r_clr) begin
        r_acc       <= '0;
        r_acc_empty <= 1'b1;
      end
    end
  end

  assign outValid  = r_out_valid;
  assign outResult = r_out_result;
  assign outZero   = r_out_zero;
  assign outCount  = r_count;

endmodule

// File: tb/tb_lab2_logic_pipe.sv
module tb_lab2_logic_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Main 8-bit instance
  logic       m_valid;
  logic [2:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_clr;
  logic       m_out_valid;
  logic [7:0] m_out_result;
  logic       m_out_zero;
  logic [7:0] m_out_count;

  // WIDTH = 1 instance
  logic       s_valid;
  logic [2:0] s_op;
  logic [0:0] s_a;
  logic [0:0] s_b;
  logic       s_clr;
  logic       s_out_valid;
  logic [0:0] s_out_result;
  logic       s_out_zero;
  logic [7:0] s_out_count;

  // COUNT_W = 4 instance
  logic       c_valid;
  logic [2:0] c_op;
  logic [7:0] c_a;
  logic [7:0] c_b;
  logic       c_clr;
  logic       c_out_valid;
  logic [7:0] c_out_result;
  logic       c_out_zero;
  logic [3:0] c_out_count;

  lab2_logic_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .inValid   (m_valid),
    .inOp      (m_op),
    .inA       (m_a),
    .inB       (m_b),
    .inClr     (m_clr),
    .outValid  (m_out_valid),
    .outResult (m_out_result),
    .outZero   (m_out_zero),
    .outCount  (m_out_count)
  );

  lab2_logic_pipe #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .reset     (reset),
    .inValid   (s_valid),
    .inOp      (s_op),
    .inA       (s_a),
    .inB       (s_b),
    .inClr     (s_clr),
    .outValid  (s_out_valid),
    .outResult (s_out_result),
    .outZero   (s_out_zero),
    .outCount  (s_out_count)
  );

  lab2_logic_pipe #(.COUNT_W(4)) dut_c4 (
    .clk       (clk),
    .reset     (reset),
    .inValid   (c_valid),
    .inOp      (c_op),
    .inA       (c_a),
    .inB       (c_b),
    .inClr     (c_clr),
    .outValid  (c_out_valid),
    .outResult (c_out_result),
    .outZero   (c_out_zero),
    .outCount  (c_out_count)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       zero;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_cnt;
  int         n_tests;
  int         n_fail;
  int         c_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] res);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.res   = res;
    e.zero  = (res == 8'h00);
    e.cnt   = exp_cnt;
    sb_q.push_back(e);
  endtask

  // Present one valid input for one cycle and queue its expected response.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic clr, input logic [7:0] res);
    m_valid = 1'b1;
    m_op    = op;
    m_a     = a;
    m_b     = b;
    m_clr   = clr;
    push(res);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    m_valid = 1'b0;
    m_clr   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops and compares whenever the main DUT strobes a result.
  always @(negedge clk) begin
    if (m_out_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got result 0x%0h, expected no output at %0t",
                 m_out_result, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", 32'(m_out_result), 32'(e.res));
        check("zero",   32'(m_out_zero),   32'(e.zero));
        check("count",  32'(m_out_count),  32'(e.cnt));
      end
    end
  end

  always @(negedge clk) begin
    if (c_out_valid) c_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // WIDTH = 1 single transaction, checked two edges later.
  task automatic scalar(input logic [2:0] op, input logic a, input logic b, input logic res,
                        input string name);
    s_valid = 1'b1;
    s_op    = op;
    s_a     = a;
    s_b     = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_valid"}, 32'(s_out_valid), 32'd1);
    check(name, 32'(s_out_result), 32'(res));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    c_seen  = 0;
    exp_cnt = 8'd0;
    reset   = 1'b1;
    m_valid = 1'b0; m_op = 3'd0; m_a = 8'h00; m_b = 8'h00; m_clr = 1'b0;
    s_valid = 1'b0; s_op = 3'd0; s_a = 1'b0;  s_b = 1'b0;  s_clr = 1'b0;
    c_valid = 1'b0; c_op = 3'd0; c_a = 8'h00; c_b = 8'h00; c_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  32'(m_out_valid),  32'd0);
    check("rst_result", 32'(m_out_result), 32'd0);
    check("rst_zero",   32'(m_out_zero),   32'd0);
    check("rst_count",  32'(m_out_count),  32'd0);
    reset = 1'b0;

    // Single AND, then outputs hold with valid low.
    issue(3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30);
    idle(2);
    check("hold_valid",  32'(m_out_valid),  32'd0);
    check("hold_result", 32'(m_out_result), 32'h30);
    check("hold_count",  32'(m_out_count),  32'd1);

    // Ops 0..5 back-to-back
    issue(3'd0, 8'hCA, 8'h5F, 1'b0, 8'h4A);
    issue(3'd1, 8'hCA, 8'h5F, 1'b0, 8'hDF);
    issue(3'd2, 8'hCA, 8'h5F, 1'b0, 8'hB5);
    issue(3'd3, 8'hCA, 8'h5F, 1'b0, 8'h20);
    issue(3'd4, 8'hCA, 8'h5F, 1'b0, 8'h95);
    issue(3'd5, 8'hCA, 8'h5F, 1'b0, 8'h6A);
    idle(3);

    // Accumulator sequences
    issue(3'd6, 8'hFF, 8'h00, 1'b1, 8'hFF);
    issue(3'd6, 8'h7E, 8'h00, 1'b0, 8'h7E);
    issue(3'd6, 8'h3C, 8'hFF, 1'b0, 8'h3C);
    issue(3'd7, 8'h01, 8'h00, 1'b1, 8'h01);
    issue(3'd7, 8'h80, 8'h00, 1'b0, 8'h81);
    m_valid = 1'b0;
    m_clr   = 1'b1;
    @(posedge clk);
    #1;
    issue(3'd7, 8'h10, 8'h00, 1'b0, 8'h10);
    // A plain op with clear empties acc but still yields its own result.
    issue(3'd1, 8'h0F, 8'h00, 1'b1, 8'h0F);
    issue(3'd6, 8'h33, 8'h00, 1'b0, 8'h33);

    // Zero flag
    issue(3'd4, 8'h55, 8'h55, 1'b0, 8'h00);
    idle(3);

    // Reset while an op sits in stage 1: it must be dropped.
    m_valid = 1'b1; m_op = 3'd0; m_a = 8'hFF; m_b = 8'hFF; m_clr = 1'b0;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_cnt = 8'd0;
    check("rstmid_valid",  32'(m_out_valid),  32'd0);
    check("rstmid_result", 32'(m_out_result), 32'd0);
    check("rstmid_count",  32'(m_out_count),  32'd0);
    @(posedge clk);
    #1;
    check("rstmid_no_valid", 32'(m_out_valid), 32'd0);
    issue(3'd6, 8'hAA, 8'h00, 1'b0, 8'hAA);
    idle(4);
    check("drain", 32'(sb_q.size()), 32'd0);

    // WIDTH = 1 instance
    scalar(3'd0, 1'b1, 1'b1, 1'b1, "w1_and11");
    scalar(3'd0, 1'b1, 1'b0, 1'b0, "w1_and10");
    scalar(3'd4, 1'b1, 1'b0, 1'b1, "w1_xor10");
    scalar(3'd3, 1'b0, 1'b0, 1'b1, "w1_nor00");

    // COUNT_W = 4 wrap: 17 results with gaps -> count wraps to 1
    c_seen = 0;
    for (int i = 0; i < 17; i++) begin
      c_valid = 1'b1;
      c_op    = 3'd1;
      c_a     = 8'(i);
      c_b     = 8'h00;
      @(posedge clk);
      #1;
      if (i % 4 == 3) begin
        c_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    c_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("c4_valids", 32'(c_seen),      32'd17);
    check("c4_count",  32'(c_out_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
